// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM state and divide-by-zero constants for md_unit
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MADD  = 3'b100;
    localparam logic [2:0] MD_MADDU = 3'b101;
    localparam logic [2:0] MD_MSUB  = 3'b110;
    localparam logic [2:0] MD_MSUBU = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Divide by zero yields an all-ones quotient and returns the dividend as remainder.
    localparam logic MD_DIV0_Q_FILL = 1'b1;

endpackage

// File: rtl/md_div_core.sv
// rtl/md_div_core.sv - combinational signed/unsigned divider with zero and overflow cases
module md_div_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;

    always_comb begin
        neg_a = is_signed & a[WIDTH-1];
        neg_b = is_signed & b[WIDTH-1];
        abs_a = neg_a ? -a : a;
        abs_b = neg_b ? -b : b;
        uq    = '0;
        ur    = '0;
        if (b != '0) begin
            uq = abs_a / abs_b;
            ur = abs_a % abs_b;
        end
        // Truncate toward zero; remainder follows the dividend's sign.
        quo = (neg_a ^ neg_b) ? -uq : uq;
        rem = neg_a ? -ur : ur;
        if (b == '0) begin
            quo = {WIDTH{MD_DIV0_Q_FILL}};
            rem = a;
        end else if (is_signed && (a == MIN_VAL) && (b == '1)) begin
            quo = MIN_VAL;
            rem = '0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO; MD_MADD_EN enables MADD/MSUB ops
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic               op_ok;
    logic               launch;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;

    md_div_core #(.WIDTH(WIDTH)) u_div (
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .quo       (div_q),
        .rem       (div_r)
    );

    always_comb begin
        is_signed = ~op[0];
`ifdef MD_MADD_EN
        op_ok     = 1'b1;
`else
        op_ok     = ~op[2];
`endif
        launch    = (state_q == IDLE) && start && op_ok;
        // Extending to 2*WIDTH makes one multiplier serve signed and unsigned modes.
        a_ext     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod      = a_ext * b_ext;
        acc       = {hi_q, lo_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(MUL_LAT);
                    unique case (op)
                        MD_MULT, MD_MULTU: {res_hi_d, res_lo_d} = prod;
                        MD_DIV, MD_DIVU: begin
                            res_hi_d = div_r;
                            res_lo_d = div_q;
                            cnt_d    = CNT_W'(DIV_LAT);
                        end
                        MD_MADD, MD_MADDU: {res_hi_d, res_lo_d} = acc + prod;
                        MD_MSUB, MD_MSUBU: {res_hi_d, res_lo_d} = acc - prod;
                        default: {res_hi_d, res_lo_d} = prod;
                    endcase
                end else if (!start) begin
                    if (we_hi) hi_d = wdata;
                    if (we_lo) lo_d = wdata;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed table-driven bench for md_unit
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input int lat, input logic [31:0] eh,
                          input logic [31:0] el);
        logic [31:0] h0;
        logic [31:0] l0;
        @(negedge clk);
        h0 = hi;
        l0 = lo;
        start = 1'b1;
        op = op_i;
        a = a_i;
        b = b_i;
        @(negedge clk);
        start = 1'b0;
        a = ~a_i;
        b = ~b_i;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            chk({nm, " busy"}, {31'b0, busy}, 32'd1);
            chk({nm, " done early"}, {31'b0, done}, 32'd0);
            chk({nm, " hi hold"}, hi, h0);
            chk({nm, " lo hold"}, lo, l0);
        end
        @(negedge clk);
        chk({nm, " busy end"}, {31'b0, busy}, 32'd0);
        chk({nm, " done"}, {31'b0, done}, 32'd1);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        @(negedge clk);
        chk({nm, " done pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        we_hi = wh;
        we_lo = wl;
        wdata = d;
        @(negedge clk);
        we_hi = 1'b0;
        we_lo = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"mult_neg",    3'b000, 32'hFFFFFFFE, 32'h00000003,  5, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{"multu_max",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"div_m7_2",    3'b010, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_by0",    3'b011, 32'h00000064, 32'h00000000, 10, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",     3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"div_by0_s",   3'b010, 32'hFFFFFFF9, 32'h00000000, 10, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{"divu_100_7",  3'b011, 32'h00000064, 32'h00000007, 10, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{"div_7_m2",    3'b010, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"mult_min2",   3'b000, 32'h80000000, 32'h80000000,  5, 32'h40000000, 32'h00000000};
        vecs[9]  = '{"multu_shift", 3'b001, 32'h12345678, 32'h00000010,  5, 32'h00000001, 32'h23456780};
        vecs[10] = '{"divu_big",    3'b011, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{"div_m1_16",   3'b010, 32'hFFFFFFFF, 32'h00000010, 10, 32'hFFFFFFFF, 32'h00000000};

        #12;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].eh, vecs[i].el);

        // DIV with an ignored MULT start and MTHI at T+3
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'hFFFFFFF9; b = 32'h2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'h5; b = 32'h5; we_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; we_hi = 1'b0;
        chk("ign busy", {31'b0, busy}, 32'd1);
        chk("ign hi hold", hi, 32'hFFFFFFFF);
        for (int k = 5; k <= 10; k++) begin
            @(negedge clk);
            chk("ign busy run", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("ign busy end", {31'b0, busy}, 32'd0);
        chk("ign done", {31'b0, done}, 32'd1);
        chk("ign hi", hi, 32'hFFFFFFFF);
        chk("ign lo", lo, 32'hFFFFFFFD);

        mt_write(1'b1, 1'b1, 32'hABCD);
        chk("mt both hi", hi, 32'hABCD);
        chk("mt both lo", lo, 32'hABCD);
        mt_write(1'b0, 1'b1, 32'h5A5A);
        chk("mtlo hi", hi, 32'hABCD);
        chk("mtlo lo", lo, 32'h5A5A);

        // start wins over a simultaneous MTHI
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'h2; b = 32'h3; we_hi = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        start = 1'b0; we_hi = 1'b0;
        chk("startwins hi", hi, 32'hABCD);
        repeat (5) @(negedge clk);
        chk("startwins res hi", hi, 32'h0);
        chk("startwins res lo", lo, 32'h6);

        // async reset mid MULT
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'h7; b = 32'h9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst busy", {31'b0, busy}, 32'd0);
        chk("arst hi", hi, 32'd0);
        chk("arst lo", lo, 32'd0);
        chk("arst done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("arst no done", {31'b0, done}, 32'd0);
            chk("arst idle", {31'b0, busy}, 32'd0);
            chk("arst lo stays", lo, 32'd0);
        end
        run_op("post_rst_mult", 3'b000, 32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);

        mt_write(1'b1, 1'b0, 32'h0);
        mt_write(1'b0, 1'b1, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
        run_op("maddu", 3'b101, 32'h1, 32'h1, 5, 32'h00000001, 32'h00000000);
        run_op("msub", 3'b110, 32'h2, 32'h3, 5, 32'h00000000, 32'hFFFFFFFA);
`else
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'h1; b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("nomadd busy", {31'b0, busy}, 32'd0);
            chk("nomadd done", {31'b0, done}, 32'd0);
            chk("nomadd hi", hi, 32'h0);
            chk("nomadd lo", lo, 32'hFFFFFFFF);
            @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits in the EX stage beside the ALU. Succeeds the bare combinational multiplier: adds divide, signed/unsigned modes, configurable latency, a busy/done handshake and MTHI/MTLO writes.
- The pipeline stalls on `busy` for any MULT/DIV/MFHI/MFLO/MTHI/MTLO that hits the unit while it is busy.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MUL_LAT, 5: busy cycles for a multiply op; must be >= 1.
- DIV_LAT, 10: busy cycles for a divide op; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch the op selected by `op`; sampled only when not busy.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- we_hi  in  1  MTHI write strobe.
- we_lo  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO first show a new op result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any time, including mid-op):
  - hi = 0, lo = 0, busy = 0, done = 0, counter = 0.
  - The in-flight op is discarded.
- States: IDLE and RUN, with a down-counter cnt.
- Launch:
  - Condition: IDLE and start = 1 at edge T. Action: latch op/a/b and compute the result into internal result registers (res_hi, res_lo). Load cnt = MUL_LAT for ops 000/001/1xx, or DIV_LAT for 010/011. Go to RUN.
  - From cycle T+1, busy = 1 for exactly LAT cycles.
  - On the edge where cnt == 1: hi/lo <= result, cnt <= 0, go to IDLE, done = 1 for the following cycle.
  - New values and busy = 0 are visible together in cycle T+LAT+1.
- Start while busy: ignored. No queueing, operands are not latched, and in-flight state is unaffected.
- MTHI/MTLO:
  - Honoured only in IDLE with start = 0: hi <= wdata, and/or lo <= wdata. Both strobes may fire in the same cycle.
  - Ignored while busy, and ignored in a cycle where a start is accepted (start wins).
- Multiply: the full 2*WIDTH product {hi, lo}. MULT is two's-complement signed; MULTU is unsigned.
- Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend. DIV is signed; DIVU is unsigned.
- Divide by zero: lo = all ones, hi = a. This is deterministic, not UNPREDICTABLE.
- Signed overflow (DIV of MIN by -1): lo = MIN, hi = 0.
- Arithmetic wraps modulo 2^(2*WIDTH). No flags.
- hi/lo change only on reset, op completion, or MTHI/MTLO. They hold at every other time, including during RUN.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: ops 1xx are accumulate ops, computed with {hi,lo} sampled at launch.
  - MADD/MADDU: {hi,lo} + a*b, signed or unsigned product.
  - MSUB/MSUBU: {hi,lo} - a*b.
  - Latency is MUL_LAT.
- Not defined: start with op[2] = 1 is ignored. No state change, busy stays 0, done stays 0.

Decomposition:
- Shared package md_pkg holds:
  - op-code localparams (MD_MULT … MD_MSUBU);
  - the state enum (IDLE, RUN);
  - the divide-by-zero result constants.
- One natural sub-module: md_div_core, the combinational signed/unsigned divider with the zero and overflow special cases. md_unit instantiates it and owns the counter, handshake and HI/LO.

Test Plan:
1. MULT, a = 0xFFFFFFFE (-2), b = 3, MUL_LAT = 5 -> busy high cycles T+1..T+5; in T+6 hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, done = 1 for that one cycle only.
2. MULTU, a = 0xFFFFFFFF, b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. DIV a = -7, b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), after exactly 10 busy cycles.
3. DIVU a = 100, b = 0 -> lo = 0xFFFFFFFF, hi = 100. DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
4. Launch DIV, then pulse start with MULT plus we_hi = 1, wdata = 0x1234 at cycle T+3 -> both ignored; final hi/lo are the DIV result. Then in IDLE, we_hi = we_lo = 1, wdata = 0xABCD -> hi = lo = 0xABCD next cycle.
5. Assert reset asynchronously at T+2 of a MULT -> busy = 0, hi = lo = 0 immediately, no done pulse. A start after release behaves as in scenario 1.
6. With MD_MADD_EN: hi = 0, lo = 0xFFFFFFFF, MADDU a = 1, b = 1 -> hi = 1, lo = 0. Without MD_MADD_EN the same start leaves busy = 0 and hi/lo unchanged.
